pipelined_barrel_shifter: RTL and testbench

Parametrised, fully pipelined logarithmic barrel shifter with four modes: rotate left, rotate right, logical right shift and arithmetic right shift.
- One registered stage per shift-amount bit; stage k conditionally shifts by 2^k.
- Valid/ready handshake on both sides; throughput 1 word/cycle.
- Sits in the datapath between operand source and ALU/result consumers; replaces the single-cycle combinational 8-bit rotator.

---
 rtl/barrel_shifter_pkg.sv | 14 +
 rtl/shift_stage.sv | 87 ++++++++
 rtl/pipelined_barrel_shifter.sv | 86 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared mode encodings for the pipelined barrel shifter.
// Used by shift_stage and pipelined_barrel_shifter.
package barrel_shifter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROL = 2'b00,
        MODE_ROR = 2'b01,
        MODE_SRL = 2'b10,
        MODE_SRA = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline stage: conditional 2^K shift plus its register.
// Optional zero flag register under BARREL_SHIFTER_ZERO_FLAG_EN.
module shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3,
    parameter int K       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_amt,
    input  logic [MODE_W-1:0]  i_mode,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic [SHAMT_W-1:0] o_amt,
    output logic [MODE_W-1:0]  o_mode
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    ,
    output logic               o_zero
`endif
);

    localparam int S = 1 << K;

    logic               w_en;
    logic [WIDTH-1:0]   w_shf;
    logic               r_v;
    logic [WIDTH-1:0]   r_d;
    logic [SHAMT_W-1:0] r_amt;
    logic [MODE_W-1:0]  r_mode;

    assign w_en    = !r_v || i_ready;
    assign o_ready = w_en;

    always_comb begin
        w_shf = i_data;
        if (i_amt[K]) begin
            unique case (mode_e'(i_mode))
                MODE_ROL: w_shf = (i_data << S) | (i_data >> (WIDTH - S));
                MODE_ROR: w_shf = (i_data >> S) | (i_data << (WIDTH - S));
                MODE_SRL: w_shf = i_data >> S;
                // MSB of the partial word is still the original sign bit
                MODE_SRA: w_shf = $signed(i_data) >>> S;
                default:  w_shf = i_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= 1'b0;
            r_d    <= '0;
            r_amt  <= '0;
            r_mode <= '0;
        end else if (w_en) begin
            r_v    <= i_valid;
            r_d    <= w_shf;
            r_amt  <= i_amt;
            r_mode <= i_mode;
        end
    end

    assign o_valid = r_v;
    assign o_data  = r_d;
    assign o_amt   = r_amt;
    assign o_mode  = r_mode;

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
        end else if (w_en) begin
            r_zero <= i_valid && (w_shf == '0);
        end
    end

    assign o_zero = r_zero;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined log barrel shifter (ROL/ROR/SRL/SRA), one stage per amt bit.
// Define BARREL_SHIFTER_ZERO_FLAG_EN to add the registered out_zero flag.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic [MODE_W-1:0]  in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    ,
    output logic               out_zero
`endif
);

    logic [SHAMT_W:0]   w_v;
    logic [SHAMT_W-1:0] w_rdy;
    logic [SHAMT_W-1:0] w_dn_rdy;
    logic [WIDTH-1:0]   w_d    [SHAMT_W+1];
    logic [SHAMT_W-1:0] w_amt  [SHAMT_W+1];
    logic [MODE_W-1:0]  w_mode [SHAMT_W+1];
    logic               w_unused;

    assign w_v[0]    = in_valid;
    assign w_d[0]    = in_data;
    assign w_amt[0]  = in_amt;
    assign w_mode[0] = in_mode;

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    logic [SHAMT_W-1:0] w_zero;
    logic               w_unused_zero;
`endif

    genvar k;
    for (k = 0; k < SHAMT_W; k++) begin : g_stage
        // Downstream ready in closed form: out_ready or any later bubble
        if (k == SHAMT_W - 1) begin : g_last
            assign w_dn_rdy[k] = out_ready;
        end else begin : g_mid
            assign w_dn_rdy[k] = out_ready || !(&w_v[SHAMT_W:k+2]);
        end

        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .K       (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_v[k]),
            .o_ready (w_rdy[k]),
            .i_data  (w_d[k]),
            .i_amt   (w_amt[k]),
            .i_mode  (w_mode[k]),
            .i_ready (w_dn_rdy[k]),
            .o_valid (w_v[k+1]),
            .o_data  (w_d[k+1]),
            .o_amt   (w_amt[k+1]),
            .o_mode  (w_mode[k+1])
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
            ,
            .o_zero  (w_zero[k])
`endif
        );
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_v[SHAMT_W];
    assign out_data  = w_d[SHAMT_W];
    assign w_unused  = ^{w_rdy, w_amt[SHAMT_W], w_mode[SHAMT_W]};

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    assign out_zero      = w_zero[SHAMT_W-1];
    assign w_unused_zero = ^w_zero;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8).
// Reference model and scoreboard compare every cycle; directed + random stimulus.
module tb_pipelined_barrel_shifter;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic [1:0] in_mode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    logic       out_zero;
`endif

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         hold_v = 0;
    logic [7:0] hold_d = '0;
    bit         s_ov = 0;
    bit         s_ir = 0;
    bit         s_fire_in = 0;
    logic [7:0] s_od = '0;
    bit         s_zero = 0;

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic [1:0] m);
        int v;
        int x;
        x = int'(d);
        case (m)
            2'b00: v = (x << a) | (x >> (8 - a));
            2'b01: v = (x >> a) | (x << (8 - a));
            2'b10: v = x >> a;
            default: begin
                v = (x >= 128) ? x - 256 : x;
                v = v >>> a;
            end
        endcase
        ref_shift = 8'(v & 255);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon();
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 0;
            s_ov = 0;
            s_fire_in = 0;
        end else begin
            s_ov = out_valid;
            s_od = out_data;
            s_ir = in_ready;
            s_fire_in = in_valid && in_ready;
            chk("in_ready", in_ready, out_ready || exp_q.size() < 3);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious out_valid", out_valid, 0);
                else chk("out_data", out_data, exp_q[0]);
                if (hold_v) chk("held out_data", out_data, hold_d);
            end else if (hold_v) begin
                chk("held out_valid", out_valid, 1);
            end
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
            s_zero = out_zero;
            chk("out_zero", out_zero, out_valid && out_data == 8'h00);
`endif
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, int'(in_amt), in_mode));
        end
    endtask

    // sample at negedge, return 1 time unit after the next posedge
    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                           input logic [7:0] ev, input string nm);
        int lat;
        bit got;
        in_valid = 1; in_data = d; in_amt = a; in_mode = m; out_ready = 1;
        step();
        chk({nm, " accept"}, s_fire_in, 1);
        in_valid = 0;
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            step();
            lat++;
            got = s_ov;
        end
        chk({nm, " latency"}, lat, 3);
        chk({nm, " data"}, s_od, ev);
    endtask

    initial begin
        int acc;
        int first;
        int last;
        int nval;
        logic [7:0] bw [4];
        logic [2:0] ba [4];
        logic [1:0] bm [4];

        #3;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset in_ready", in_ready, 1);
        step();
        step();
        rst_n = 1;

        run_one(8'h81, 3'd1, 2'b00, 8'h03, "ROL 81/1");
        run_one(8'h81, 3'd3, 2'b01, 8'h30, "ROR 81/3");
        run_one(8'h80, 3'd7, 2'b10, 8'h01, "SRL 80/7");
        run_one(8'h80, 3'd7, 2'b11, 8'hFF, "SRA 80/7");
        run_one(8'h70, 3'd2, 2'b11, 8'h1C, "SRA 70/2");
        run_one(8'h7F, 3'd7, 2'b11, 8'h00, "SRA 7F/7");
        run_one(8'hA5, 3'd0, 2'b00, 8'hA5, "ROL amt0");
        run_one(8'hA5, 3'd0, 2'b01, 8'hA5, "ROR amt0");
        run_one(8'hA5, 3'd0, 2'b10, 8'hA5, "SRL amt0");
        run_one(8'hA5, 3'd0, 2'b11, 8'hA5, "SRA amt0");
        run_one(8'hC3, 3'd4, 2'b01, 8'h3C, "ROR C3/4");

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
        run_one(8'h01, 3'd1, 2'b10, 8'h00, "SRL 01/1");
        chk("zero flag set", s_zero, 1);
        run_one(8'h01, 3'd1, 2'b00, 8'h02, "ROL 01/1");
        chk("zero flag clear", s_zero, 0);
`endif

        // streaming: 8 back-to-back words
        first = -1;
        last = -1;
        nval = 0;
        out_ready = 1;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) begin
                in_valid = 1;
                in_data = 8'($urandom);
                in_amt = 3'($urandom);
                in_mode = 2'($urandom);
            end else begin
                in_valid = 0;
            end
            step();
            if (i < 8) chk("stream in_ready", s_ir, 1);
            if (s_ov) begin
                nval++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("stream count", nval, 8);
        chk("stream consecutive", last - first + 1, 8);

        // backpressure: out_ready low, offer 4 words
        for (int i = 0; i < 4; i++) begin
            bw[i] = 8'($urandom);
            ba[i] = 3'($urandom);
            bm[i] = 2'($urandom);
        end
        out_ready = 0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_data = bw[acc]; in_amt = ba[acc]; in_mode = bm[acc];
            step();
            if (s_fire_in) acc++;
        end
        chk("bp accepted", acc, 3);
        chk("bp in_ready", s_ir, 0);
        chk("bp out_valid", s_ov, 1);
        out_ready = 1;
        for (int i = 0; i < 10 && acc < 4; i++) begin
            in_valid = 1; in_data = bw[acc]; in_amt = ba[acc]; in_mode = bm[acc];
            step();
            if (s_fire_in) acc++;
        end
        in_valid = 0;
        chk("bp 4th accepted", acc, 4);
        for (int i = 0; i < 20 && (exp_q.size() > 0 || s_ov); i++) step();
        chk("bp drained", exp_q.size(), 0);

        // reset with two words in flight
        out_ready = 0;
        in_valid = 1; in_data = 8'h81; in_amt = 3'd1; in_mode = 2'b00;
        step();
        chk("rst word A accept", s_fire_in, 1);
        in_data = 8'h81; in_amt = 3'd3; in_mode = 2'b01;
        step();
        chk("rst word B accept", s_fire_in, 1);
        in_valid = 0;
        step();
        step();
        chk("pre-reset out_valid", s_ov, 1);
        #1 rst_n = 0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        chk("async rst in_ready", in_ready, 1);
        step();
        rst_n = 1;
        run_one(8'h01, 3'd7, 2'b00, 8'h80, "post-reset ROL 01/7");

        // randomized traffic
        in_valid = 0;
        s_fire_in = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || s_fire_in) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data = 8'($urandom);
                in_amt = 3'($urandom);
                in_mode = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || s_ov); i++) step();
        chk("final drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
